// File: rtl/inst_trace_buffer_pkg.sv
// Shared definitions for the instruction trace buffer.
// Holds the CPU bus widths, the default trace depth, the FSM state encoding
// and the packed trace entry layout used by the buffer and its storage FIFO.
package inst_trace_buffer_pkg;

    localparam int unsigned ADDR_LEN      = 32;
    localparam int unsigned DATA_LEN      = 32;
    localparam int unsigned SEQ_LEN       = 16;
    localparam int unsigned DEFAULT_DEPTH = 16;

    // Encoding is visible on the state port, so the values are fixed.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPost  = 2'd2,
        StDone  = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [ADDR_LEN-1:0] pc;
        logic [DATA_LEN-1:0] inst;
        logic [SEQ_LEN-1:0]  seq;
    } trace_entry_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SEQ_LEN-1:0] sat_inc(input logic [SEQ_LEN-1:0] v);
        return (v == '1) ? v : v + SEQ_LEN'(1);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace storage with overwrite-on-full.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush_i           empty the FIFO (priority over push/pop)
//   push_i, wdata_i   write an entry at the tail; when full the oldest is dropped
//   pop_i             drop the head entry (ignored when empty)
//   rdata_o           head entry (raw storage, meaningless while empty)
//   count_o           number of stored entries, 0..DEPTH
//   full_o, empty_o   count_o == DEPTH / count_o == 0
//   ovw_o             this cycle's push overwrites the oldest entry
module trace_fifo
    import inst_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  trace_entry_t           wdata_i,
    input  logic                   pop_i,
    output trace_entry_t           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   ovw_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PtrOne  = AW'(1);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);

    trace_entry_t  mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    assign full_o  = (count_q == CntFull);
    assign empty_o = (count_q == '0);
    assign ovw_o   = push_i & full_o & ~flush_i;
    assign count_o = count_q;
    assign rdata_o = mem_q[head_q];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (push_i) begin
            tail_d = tail_q + PtrOne;
            if (full_o) begin
                head_d = head_q + PtrOne;
            end else begin
                count_d = count_q + CntOne;
            end
        end else if (pop_i && !empty_o) begin
            head_d  = head_q + PtrOne;
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; contents are never visible while empty.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[tail_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/inst_trace_buffer.sv
// Instruction trace buffer: records {pc, inst, seq} whenever the CPU pc changes
// while capture is armed, with an optional pc trigger followed by a fixed
// number of post-trigger entries. Entries are read out once capture stops.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   pc_in, inst_in               CPU pc and instruction register
//   arm, stop, clr               start capture / freeze / flush and idle
//   trig_en, trig_pc, post_cnt   pc trigger enable, address, post-trigger entries
//   rd_ready / rd_valid          head entry handshake (only in IDLE or DONE)
//   rd_pc, rd_inst, rd_seq       head entry, zero when rd_valid is low
//   count, full, empty           FIFO occupancy
//   triggered, ovw_cnt, state    trigger seen, overwritten entries, FSM state
module inst_trace_buffer
    import inst_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_LEN-1:0]    pc_in,
    input  logic [DATA_LEN-1:0]    inst_in,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   clr,
    input  logic                   trig_en,
    input  logic [ADDR_LEN-1:0]    trig_pc,
    input  logic [7:0]             post_cnt,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [ADDR_LEN-1:0]    rd_pc,
    output logic [DATA_LEN-1:0]    rd_inst,
    output logic [SEQ_LEN-1:0]     rd_seq,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   triggered,
    output logic [SEQ_LEN-1:0]     ovw_cnt,
    output logic [1:0]             state
);

    trace_state_e        state_q, state_d;
    logic [ADDR_LEN-1:0] pc_q;
    logic [SEQ_LEN-1:0]  seq_q, seq_d;
    logic [SEQ_LEN-1:0]  ovw_q, ovw_d;
    logic                trig_q, trig_d;
    logic [7:0]          remain_q, remain_d;

    logic         capturing;
    logic         event_hit;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_flush;
    logic         fifo_ovw;
    logic         fifo_empty;
    trace_entry_t fifo_wdata;
    trace_entry_t fifo_rdata;

    assign capturing  = (state_q == StArmed) || (state_q == StPost);
    assign event_hit  = capturing && (pc_in != pc_q);
    assign fifo_push  = event_hit && !clr;
    assign fifo_wdata = '{pc: pc_in, inst: inst_in, seq: seq_q};

    // Reading is only allowed while not capturing, so push and pop never overlap.
    assign rd_valid = !fifo_empty && !capturing;
    assign fifo_pop = rd_valid && rd_ready;
    assign rd_pc    = rd_valid ? fifo_rdata.pc   : '0;
    assign rd_inst  = rd_valid ? fifo_rdata.inst : '0;
    assign rd_seq   = rd_valid ? fifo_rdata.seq  : '0;

    assign empty     = fifo_empty;
    assign triggered = trig_q;
    assign ovw_cnt   = ovw_q;
    assign state     = state_q;

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        ovw_d      = ovw_q;
        trig_d     = trig_q;
        remain_d   = remain_q;
        fifo_flush = 1'b0;
        if (clr) begin
            state_d    = StIdle;
            fifo_flush = 1'b1;
            seq_d      = '0;
            ovw_d      = '0;
            trig_d     = 1'b0;
            remain_d   = '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (arm) begin
                        state_d    = StArmed;
                        fifo_flush = 1'b1;
                        seq_d      = '0;
                        ovw_d      = '0;
                        trig_d     = 1'b0;
                        remain_d   = post_cnt;
                    end
                end
                StArmed: begin
                    if (event_hit && trig_en && (pc_in == trig_pc)) begin
                        trig_d  = 1'b1;
                        state_d = (remain_q == 8'd0) ? StDone : StPost;
                    end
                    if (stop) begin
                        state_d = StDone;
                    end
                end
                StPost: begin
                    if (event_hit) begin
                        remain_d = remain_q - 8'd1;
                        if (remain_q == 8'd1) begin
                            state_d = StDone;
                        end
                    end
                    if (stop) begin
                        state_d = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (event_hit) begin
                seq_d = seq_q + SEQ_LEN'(1);
                if (fifo_ovw) begin
                    ovw_d = sat_inc(ovw_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            seq_q    <= '0;
            ovw_q    <= '0;
            trig_q   <= 1'b0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_in;
            seq_q    <= seq_d;
            ovw_q    <= ovw_d;
            trig_q   <= trig_d;
            remain_q <= remain_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (count),
        .full_o  (full),
        .empty_o (fifo_empty),
        .ovw_o   (fifo_ovw)
    );

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Randomised and directed bench for inst_trace_buffer with a queue-based
// reference model; a negedge monitor pops expected entries on every read.
module tb_inst_trace_buffer;
    import inst_trace_buffer_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [ADDR_LEN-1:0] pc_in = '0;
    logic [DATA_LEN-1:0] inst_in = '0;
    logic                arm = 1'b0, stop = 1'b0, clr = 1'b0, trig_en = 1'b0;
    logic [ADDR_LEN-1:0] trig_pc = '0;
    logic [7:0]          post_cnt = '0;
    logic                rd_ready = 1'b0;
    logic                rd_valid;
    logic [ADDR_LEN-1:0] rd_pc;
    logic [DATA_LEN-1:0] rd_inst;
    logic [SEQ_LEN-1:0]  rd_seq;
    logic [CW-1:0]       count;
    logic                full, empty, triggered;
    logic [SEQ_LEN-1:0]  ovw_cnt;
    logic [1:0]          state;

    always #5 clk = ~clk;

    inst_trace_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_in     (pc_in),
        .inst_in   (inst_in),
        .arm       (arm),
        .stop      (stop),
        .clr       (clr),
        .trig_en   (trig_en),
        .trig_pc   (trig_pc),
        .post_cnt  (post_cnt),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_pc     (rd_pc),
        .rd_inst   (rd_inst),
        .rd_seq    (rd_seq),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .triggered (triggered),
        .ovw_cnt   (ovw_cnt),
        .state     (state)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: 0 idle, 1 armed, 2 post, 3 done.
    trace_entry_t        m_fifo[$];
    trace_entry_t        exp_q[$];
    int                  m_state = 0;
    logic [ADDR_LEN-1:0] m_pc_prev = '0;
    logic [SEQ_LEN-1:0]  m_seq = '0;
    int                  m_ovw = 0;
    bit                  m_trig = 1'b0;
    int                  m_remain = 0;
    logic [ADDR_LEN-1:0] last_pc = '0;
    logic [SEQ_LEN-1:0]  last_seq = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_state   = 0;
        m_pc_prev = '0;
        m_seq     = '0;
        m_ovw     = 0;
        m_trig    = 1'b0;
        m_remain  = 0;
    endfunction

    // One clock of the trace buffer's rules, applied to the current inputs.
    function automatic void model_step();
        bit           busy, ev, pop;
        trace_entry_t e;
        busy = (m_state == 1) || (m_state == 2);
        ev   = busy && (pc_in != m_pc_prev);
        pop  = !busy && (m_fifo.size() > 0) && rd_ready;
        m_pc_prev = pc_in;
        if (clr) begin
            m_fifo.delete();
            m_state = 0; m_seq = '0; m_ovw = 0; m_trig = 1'b0; m_remain = 0;
            return;
        end
        if (!busy && arm) begin
            m_fifo.delete();
            m_state = 1; m_seq = '0; m_ovw = 0; m_trig = 1'b0; m_remain = int'(post_cnt);
            return;
        end
        if (pop) exp_q.push_back(m_fifo.pop_front());
        if (ev) begin
            if (m_fifo.size() == int'(DEPTH)) begin
                m_fifo.delete(0);
                if (m_ovw < 65535) m_ovw++;
            end
            e.pc   = pc_in;
            e.inst = inst_in;
            e.seq  = m_seq;
            m_fifo.push_back(e);
            m_seq++;
            if (m_state == 1 && trig_en && pc_in == trig_pc) begin
                m_trig  = 1'b1;
                m_state = (m_remain == 0) ? 3 : 2;
            end else if (m_state == 2) begin
                m_remain--;
                if (m_remain == 0) m_state = 3;
            end
        end
        if (busy && stop) m_state = 3;
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [ADDR_LEN-1:0] pc);
        pc_in   = pc;
        inst_in = $urandom;
        cyc();
    endtask

    task automatic check_status(input string name);
        bit mv;
        mv = (m_fifo.size() > 0) && (m_state == 0 || m_state == 3);
        chk({name, ".state"}, 64'(state), 64'(m_state));
        chk({name, ".count"}, 64'(count), 64'(m_fifo.size()));
        chk({name, ".full"}, 64'(full), 64'(m_fifo.size() == int'(DEPTH)));
        chk({name, ".empty"}, 64'(empty), 64'(m_fifo.size() == 0));
        chk({name, ".triggered"}, 64'(triggered), 64'(m_trig));
        chk({name, ".ovw_cnt"}, 64'(ovw_cnt), 64'(m_ovw));
        chk({name, ".rd_valid"}, 64'(rd_valid), 64'(mv));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {arm, stop, clr, trig_en, rd_ready} = '0;
        pc_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic start_arm();
        arm   = 1'b1;
        pc_in = '0;
        cyc();
        arm = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic drain(input string name);
        rd_ready = 1'b1;
        for (int i = 0; i < int'(DEPTH) + 2 && m_fifo.size() > 0; i++) cyc();
        rd_ready = 1'b0;
        chk({name, ".drain_empty"}, 64'(empty), 64'(1));
        chk({name, ".drain_sb"}, 64'(exp_q.size()), 64'(0));
    endtask

    // Monitor: every accepted read is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 64'(1), 64'(0));
                end else begin
                    trace_entry_t e;
                    e = exp_q.pop_front();
                    chk("rd_pc", 64'(rd_pc), 64'(e.pc));
                    chk("rd_inst", 64'(rd_inst), 64'(e.inst));
                    chk("rd_seq", 64'(rd_seq), 64'(e.seq));
                    last_pc  = rd_pc;
                    last_seq = rd_seq;
                end
            end else if (!rd_valid) begin
                chk("rd_zero", 64'(rd_pc) | 64'(rd_inst) | 64'(rd_seq), 64'(0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        check_status("reset");
        chk("reset.state0", 64'(state), 64'(0));
        chk("reset.empty1", 64'(empty), 64'(1));
        chk("reset.full0", 64'(full), 64'(0));
        chk("reset.rdv0", 64'(rd_valid), 64'(0));

        // Three pc changes, stop, read back in order
        start_arm();
        step(32'h4); step(32'h8); step(32'hC);
        check_status("a.cap");
        chk("a.count3", 64'(count), 64'(3));
        do_stop();
        check_status("a.stop");
        chk("a.done", 64'(state), 64'(3));
        drain("a");
        chk("a.lastpc", 64'(last_pc), 64'(32'hC));
        chk("a.lastseq", 64'(last_seq), 64'(2));

        // Overwrite on full
        start_arm();
        for (int i = 1; i <= 20; i++) step(32'(i * 4));
        do_stop();
        check_status("b.stop");
        chk("b.count16", 64'(count), 64'(16));
        chk("b.ovw4", 64'(ovw_cnt), 64'(4));
        drain("b");
        chk("b.lastseq", 64'(last_seq), 64'(19));

        // Trigger with post count 3
        trig_en  = 1'b1;
        trig_pc  = 32'h20;
        post_cnt = 8'd3;
        start_arm();
        for (int i = 1; i < 40 && state != 2'd3; i++) step(32'(i * 4));
        check_status("c.done");
        chk("c.state", 64'(state), 64'(3));
        chk("c.trig", 64'(triggered), 64'(1));
        chk("c.count", 64'(count), 64'(11));
        drain("c");
        chk("c.lastpc", 64'(last_pc), 64'(32'h2C));

        // Trigger with post count 0
        trig_pc  = 32'h10;
        post_cnt = 8'd0;
        start_arm();
        step(32'h4); step(32'h8); step(32'hC);
        chk("d.armed", 64'(state), 64'(1));
        step(32'h10);
        chk("d.done", 64'(state), 64'(3));
        step(32'h14);
        check_status("d.after");
        chk("d.count4", 64'(count), 64'(4));
        drain("d");
        chk("d.lastpc", 64'(last_pc), 64'(32'h10));
        trig_en = 1'b0;

        // clr beats arm; rd_ready ignored while armed
        start_arm();
        step(32'h4); step(32'h8);
        do_stop();
        chk("e.rdv", 64'(rd_valid), 64'(1));
        clr = 1'b1; arm = 1'b1;
        cyc();
        clr = 1'b0; arm = 1'b0;
        check_status("e.clr");
        chk("e.idle", 64'(state), 64'(0));
        chk("e.empty", 64'(empty), 64'(1));
        start_arm();
        step(32'h4); step(32'h8); step(32'hC);
        rd_ready = 1'b1;
        repeat (3) cyc();
        rd_ready = 1'b0;
        check_status("e.hold");
        chk("e.count3", 64'(count), 64'(3));
        do_stop();
        drain("e");

        // Asynchronous reset in POST with five entries
        trig_en  = 1'b1;
        trig_pc  = 32'h8;
        post_cnt = 8'd10;
        start_arm();
        step(32'h4); step(32'h8); step(32'hC); step(32'h10); step(32'h14);
        check_status("f.post");
        chk("f.state2", 64'(state), 64'(2));
        chk("f.count5", 64'(count), 64'(5));
        rd_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("f.rst_state", 64'(state), 64'(0));
        chk("f.rst_count", 64'(count), 64'(0));
        chk("f.rst_rdv", 64'(rd_valid), 64'(0));
        chk("f.rst_empty", 64'(empty), 64'(1));
        do_reset();
        check_status("f.after");

        // Randomised sessions
        for (int r = 0; r < 6; r++) begin
            post_cnt = 8'($urandom_range(0, 6));
            trig_en  = 1'($urandom % 2);
            trig_pc  = 32'($urandom_range(0, 7) * 4);
            start_arm();
            for (int c = 0; c < 60; c++) begin
                pc_in    = 32'($urandom_range(0, 7) * 4);
                inst_in  = $urandom;
                stop     = ($urandom % 16) == 0;
                rd_ready = 1'($urandom % 2);
                clr      = ($urandom % 64) == 0;
                arm      = ($urandom % 32) == 0;
                cyc();
                check_status("rnd");
            end
            {stop, clr, arm, rd_ready} = '0;
            do_stop();
            drain("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_trace_buffer.md
INST_TRACE_BUFFER -- requirements
Module: inst_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, entry count; SHALL be a power of two, at least 4.
REQ-002 Port clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Ports pc_in  in  `ADDR_LEN, and inst_in  in  `DATA_LEN; CPU pc and instruction-register outputs.
REQ-005 Control inputs, all 1 bit: arm starts capture; stop forces freeze; clr flushes and idles; trig_en enables PC trigger.
REQ-006 Ports trig_pc  in  `ADDR_LEN, trigger address; post_cnt  in  8, entries captured after trigger.
REQ-007 Port rd_ready  in  1, reader accepts the head entry.
REQ-008 Port rd_valid  out  1, head entry available.
REQ-009 Ports rd_pc  out  `ADDR_LEN, rd_inst  out  `DATA_LEN, rd_seq  out  16; head entry fields.
REQ-010 Status outputs: count  out  log2(DEPTH)+1; full, empty, triggered  out  1 each; ovw_cnt  out  16; state  out  2.

Function
REQ-011 FSM states SHALL be IDLE=0, ARMED=1, POST=2, DONE=3, visible on state.
REQ-012 Register pc_q SHALL capture pc_in every cycle.
REQ-013 Event SHALL be asserted in a cycle iff pc_in != pc_q and state is ARMED or POST.
REQ-014 Each event SHALL write {pc_in, inst_in, seq} to the tail; count updates on the same edge, one-cycle latency.
REQ-015 seq SHALL be a 16-bit counter of events since arm, stored and then incremented, wrapping at 0xFFFF.
REQ-016 Event when full SHALL overwrite the oldest entry: head advances, count holds, ovw_cnt increments, saturating at 0xFFFF.
REQ-017 IDLE/DONE + arm -> ARMED: FIFO emptied, seq=0, ovw_cnt=0, triggered=0, post_cnt latched; arm in ARMED/POST ignored.
REQ-018 ARMED + event with trig_en=1 and pc_in==trig_pc: trigger entry is captured and triggered is set; next state is POST, or DONE if latched post_cnt==0.
REQ-019 POST: each event decrements the remaining counter; the event taking it to 0 is captured and next state is DONE.
REQ-020 stop in ARMED or POST -> DONE; a same-cycle event is still captured.
REQ-021 clr SHALL have priority over arm and stop, giving IDLE, empty FIFO and zeroed counters; if arm and stop coincide, arm wins.
REQ-022 rd_valid = !empty and state in {IDLE, DONE}; rd_* SHALL be combinational from head and zero when rd_valid=0.
REQ-023 Pop on rd_valid and rd_ready; head advances, count decrements; pointers wrap modulo DEPTH.
REQ-024 rd_ready without rd_valid SHALL have no effect; no pops in ARMED/POST, so event and pop never coincide.
REQ-025 full = (count==DEPTH); empty = (count==0).

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE; pc_q, pointers, count, seq, ovw_cnt, triggered and remaining counter to 0.
REQ-027 After reset, rd_valid=0, empty=1, full=0; reset mid-POST discards all entries with no partial pop.
REQ-028 Storage RAM content need not reset; it is unobservable while empty.

Structure
REQ-029 State encodings and default DEPTH SHALL live in the shared defines header beside `ADDR_LEN/`DATA_LEN.
REQ-030 Circular storage SHALL be sub-module trace_fifo: push, overwrite-on-full, pop, count, flush; the FSM, trigger and counters stay in inst_trace_buffer.

Verification
REQ-031 Arm, pc 0->4->8->C -> three entries, seq 0,1,2; stop -> DONE; pops return pc 4,8,C in order.
REQ-032 DEPTH=16, 20 events in ARMED, stop -> count=16, ovw_cnt=4, first pop seq=4, last seq=19.
REQ-033 trig_pc=0x20, post_cnt=3, pc steps of 4 from 0 -> DONE after pc 0x2C; triggered=1; last pop pc=0x2C.
REQ-034 post_cnt=0, trigger hit at 0x10 -> DONE the next cycle; last entry pc=0x10.
REQ-035 clr with arm in DONE -> IDLE, empty=1; rd_ready held high in ARMED -> count unchanged.
REQ-036 rst_n low mid-POST with 5 entries -> immediately state=0, count=0, rd_valid=0.
